// File: rtl/lc3_mmio_pkg.sv
// rtl/lc3_mmio_pkg.sv - LC-3 memory-mapped I/O addresses, vectors and status bit positions
package lc3_mmio_pkg;

    localparam logic [15:0] IO_BASE   = 16'hFE00;
    localparam logic [15:0] ADDR_KBSR = 16'hFE00;
    localparam logic [15:0] ADDR_KBDR = 16'hFE02;
    localparam logic [15:0] ADDR_DSR  = 16'hFE04;
    localparam logic [15:0] ADDR_DDR  = 16'hFE06;
    localparam logic [15:0] ADDR_MCR  = 16'hFFFE;

    localparam logic [7:0] VEC_KB   = 8'h80;
    localparam logic [7:0] VEC_DISP = 8'h81;

    localparam int STAT_RDY = 15;
    localparam int STAT_IE  = 14;

endpackage

// File: rtl/lc3_mmio_devices_if.sv
// rtl/lc3_mmio_devices_if.sv - datapath bus, keyboard, display and interrupt signals of the MMIO block
interface lc3_mmio_devices_if;
    logic [15:0] mmio_addr;
    logic [15:0] mmio_wdata;
    logic        mmio_we;
    logic        mmio_re;
    logic [15:0] mmio_rdata;
    logic        kb_valid;
    logic [7:0]  kb_data;
    logic        kb_ready;
    logic        disp_valid;
    logic [7:0]  disp_data;
    logic        disp_ready;
    logic        irq;
    logic [2:0]  int_prio;
    logic [7:0]  int_vec;
    logic        mcr_run;

    modport master (
        output mmio_addr, mmio_wdata, mmio_we, mmio_re, kb_valid, kb_data, disp_ready,
        input  mmio_rdata, kb_ready, disp_valid, disp_data, irq, int_prio, int_vec, mcr_run
    );

    modport slave (
        input  mmio_addr, mmio_wdata, mmio_we, mmio_re, kb_valid, kb_data, disp_ready,
        output mmio_rdata, kb_ready, disp_valid, disp_data, irq, int_prio, int_vec, mcr_run
    );
endinterface

// File: rtl/lc3_sync_fifo.sv
// rtl/lc3_sync_fifo.sv - single-clock FIFO with wrapping pointers and an occupancy count
module lc3_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Storage array carries no reset; only entries below count are ever observed
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally; a simultaneous push and pop leaves the count unchanged
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/lc3_mmio_devices.sv
// rtl/lc3_mmio_devices.sv - LC-3 keyboard, display and MCR devices with interrupt arbitration
module lc3_mmio_devices
    import lc3_mmio_pkg::*;
#(
    parameter int         KB_DEPTH  = 4,
    parameter logic [2:0] KB_PRIO   = 3'd4,
    parameter logic [2:0] DISP_PRIO = 3'd4
) (
    input logic               clk,
    input logic               rst,
    lc3_mmio_devices_if.slave bus
);
    logic       kie;
    logic       die;
    logic       mcr_run_q;
    logic       disp_valid_q;
    logic [7:0] disp_data_q;
    logic       pend_q;
    logic       irq_q;
    logic [2:0] prio_q;
    logic [7:0] vec_q;

    logic       kb_full;
    logic       kb_empty;
    logic [7:0] kb_head;
    logic       kb_push;
    logic       kb_pop;
    logic       disp_idle;
    logic       kb_pend;
    logic       disp_pend;
    logic       wr_kbsr;
    logic       wr_dsr;
    logic       wr_ddr;
    logic       wr_mcr;

    assign kb_push   = bus.kb_valid && !kb_full;
    assign kb_pop    = bus.mmio_re && (bus.mmio_addr == ADDR_KBDR) && !kb_empty;
    assign disp_idle = !disp_valid_q;
    assign kb_pend   = kie && !kb_empty;
    assign disp_pend = die && disp_idle;

    assign wr_kbsr = bus.mmio_we && (bus.mmio_addr == ADDR_KBSR);
    assign wr_dsr  = bus.mmio_we && (bus.mmio_addr == ADDR_DSR);
    assign wr_ddr  = bus.mmio_we && (bus.mmio_addr == ADDR_DDR);
    assign wr_mcr  = bus.mmio_we && (bus.mmio_addr == ADDR_MCR);

    lc3_sync_fifo #(.WIDTH(8), .DEPTH(KB_DEPTH)) u_kb_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (kb_push),
        .push_data (bus.kb_data),
        .pop       (kb_pop),
        .head      (kb_head),
        .full      (kb_full),
        .empty     (kb_empty)
    );

    // Read mux: decoded straight from the address so data is ready with no wait state
    always_comb begin
        bus.mmio_rdata = '0;
        case (bus.mmio_addr)
            ADDR_KBSR: begin
                bus.mmio_rdata[STAT_RDY] = !kb_empty;
                bus.mmio_rdata[STAT_IE]  = kie;
            end
            ADDR_KBDR: if (!kb_empty) bus.mmio_rdata[7:0] = kb_head;
            ADDR_DSR: begin
                bus.mmio_rdata[STAT_RDY] = disp_idle;
                bus.mmio_rdata[STAT_IE]  = die;
            end
            ADDR_MCR:  bus.mmio_rdata[15] = mcr_run_q;
            default:   bus.mmio_rdata = '0;
        endcase
    end

    // Control registers and the display transmitter; a DDR write while busy is dropped
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            kie          <= 1'b0;
            die          <= 1'b0;
            mcr_run_q    <= 1'b1;
            disp_valid_q <= 1'b0;
            disp_data_q  <= '0;
        end else begin
            if (wr_kbsr) kie       <= bus.mmio_wdata[STAT_IE];
            if (wr_dsr)  die       <= bus.mmio_wdata[STAT_IE];
            if (wr_mcr)  mcr_run_q <= bus.mmio_wdata[15];
            if (wr_ddr && disp_idle) begin
                disp_valid_q <= 1'b1;
                disp_data_q  <= bus.mmio_wdata[7:0];
            end else if (disp_valid_q && bus.disp_ready) begin
                disp_valid_q <= 1'b0;
            end
        end
    end

    // Interrupt arbiter: keyboard first; irq stays up one extra cycle so priority 0 is relatched
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend_q <= 1'b0;
            irq_q  <= 1'b0;
            prio_q <= '0;
            vec_q  <= '0;
        end else begin
            pend_q <= kb_pend || disp_pend;
            irq_q  <= kb_pend || disp_pend || pend_q;
            if (kb_pend) begin
                prio_q <= KB_PRIO;
                vec_q  <= VEC_KB;
            end else if (disp_pend) begin
                prio_q <= DISP_PRIO;
                vec_q  <= VEC_DISP;
            end else begin
                prio_q <= '0;
                vec_q  <= '0;
            end
        end
    end

    assign bus.kb_ready   = !kb_full;
    assign bus.disp_valid = disp_valid_q;
    assign bus.disp_data  = disp_data_q;
    assign bus.irq        = irq_q;
    assign bus.int_prio   = prio_q;
    assign bus.int_vec    = vec_q;
    assign bus.mcr_run    = mcr_run_q;
endmodule

// File: tb/tb_lc3_mmio_devices.sv
// tb/tb_lc3_mmio_devices.sv - directed and randomized checks of the LC-3 MMIO device block
module tb_lc3_mmio_devices;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    lc3_mmio_devices_if bus ();

    lc3_mmio_devices dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [15:0] addr, input logic [15:0] data);
        bus.mmio_addr  = addr;
        bus.mmio_wdata = data;
        bus.mmio_we    = 1'b1;
        tick();
        bus.mmio_we    = 1'b0;
    endtask

    task automatic read_chk(input string tag, input logic [15:0] addr, input logic [15:0] exp);
        bus.mmio_addr = addr;
        #1;
        chk(tag, bus.mmio_rdata, exp);
    endtask

    task automatic kbdr_pop(input string tag, input logic [15:0] exp);
        bus.mmio_addr = 16'hFE02;
        bus.mmio_re   = 1'b1;
        #1;
        chk(tag, bus.mmio_rdata, exp);
        tick();
        bus.mmio_re   = 1'b0;
    endtask

    logic [7:0] model_q[$];
    logic [7:0] chars [5];

    initial begin
        checks = 0;
        errors = 0;
        chars[0] = 8'h41; chars[1] = 8'h42; chars[2] = 8'h43; chars[3] = 8'h44; chars[4] = 8'h45;
        rst = 1'b0;
        bus.mmio_addr = 16'h0000; bus.mmio_wdata = 16'h0000;
        bus.mmio_we = 1'b0; bus.mmio_re = 1'b0;
        bus.kb_valid = 1'b0; bus.kb_data = 8'h00; bus.disp_ready = 1'b0;
        tick(); tick();
        rst = 1'b1;
        tick();

        // reset state
        read_chk("rst_kbsr", 16'hFE00, 16'h0000);
        read_chk("rst_dsr",  16'hFE04, 16'h8000);
        read_chk("rst_mcr",  16'hFFFE, 16'h8000);
        read_chk("rst_kbdr_empty", 16'hFE02, 16'h0000);
        chk("rst_kb_ready", {15'd0, bus.kb_ready}, 16'd1);
        chk("rst_irq", {15'd0, bus.irq}, 16'd0);
        chk("rst_disp_valid", {15'd0, bus.disp_valid}, 16'd0);

        // fill the FIFO: 'E' offered while full is refused
        bus.kb_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus.kb_data = chars[i];
            tick();
            if (i == 0) read_chk("kbsr_after_first_push", 16'hFE00, 16'h8000);
            if (i == 3) chk("kb_ready_full", {15'd0, bus.kb_ready}, 16'd0);
        end
        bus.kb_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            kbdr_pop($sformatf("kbdr_pop%0d", i), {8'h00, chars[i]});
            if (i == 0) chk("kb_ready_after_pop", {15'd0, bus.kb_ready}, 16'd1);
        end
        read_chk("kbsr_drained", 16'hFE00, 16'h0000);

        // display: second write while busy is dropped
        bus.disp_ready = 1'b0;
        bus_write(16'hFE06, 16'h0048);
        chk("disp_valid_set", {15'd0, bus.disp_valid}, 16'd1);
        read_chk("dsr_busy", 16'hFE04, 16'h0000);
        read_chk("ddr_reads0", 16'hFE06, 16'h0000);
        bus_write(16'hFE06, 16'h0049);
        chk("disp_data_kept", {8'h00, bus.disp_data}, 16'h0048);
        bus.disp_ready = 1'b1;
        tick();
        bus.disp_ready = 1'b0;
        read_chk("dsr_idle", 16'hFE04, 16'h8000);
        chk("disp_data_hold", {8'h00, bus.disp_data}, 16'h0048);
        chk("disp_valid_clr", {15'd0, bus.disp_valid}, 16'd0);

        // keyboard interrupt and the priority-0 refresh cycle
        bus_write(16'hFE00, 16'h4000);
        read_chk("kbsr_kie", 16'hFE00, 16'h4000);
        bus.kb_valid = 1'b1; bus.kb_data = 8'h78;
        tick();
        bus.kb_valid = 1'b0;
        tick();
        chk("kb_irq", {15'd0, bus.irq}, 16'd1);
        chk("kb_prio", {13'd0, bus.int_prio}, 16'd4);
        chk("kb_vec", {8'd0, bus.int_vec}, 16'h0080);
        kbdr_pop("kbdr_x", 16'h0078);
        tick();
        chk("refresh_irq", {15'd0, bus.irq}, 16'd1);
        chk("refresh_prio", {13'd0, bus.int_prio}, 16'd0);
        tick();
        chk("irq_cleared", {15'd0, bus.irq}, 16'd0);

        // keyboard beats display, then display takes over
        bus_write(16'hFE04, 16'h4000);
        read_chk("dsr_die", 16'hFE04, 16'hC000);
        bus.kb_valid = 1'b1; bus.kb_data = 8'h31;
        tick();
        bus.kb_valid = 1'b0;
        tick();
        chk("both_vec", {8'd0, bus.int_vec}, 16'h0080);
        kbdr_pop("kbdr_1", 16'h0031);
        tick();
        chk("disp_vec", {8'd0, bus.int_vec}, 16'h0081);
        chk("disp_prio", {13'd0, bus.int_prio}, 16'd4);
        bus_write(16'hFE00, 16'h0000);
        bus_write(16'hFE04, 16'h0000);

        // MCR stop, then reset in the middle of activity
        bus_write(16'hFFFE, 16'h0000);
        chk("mcr_stop", {15'd0, bus.mcr_run}, 16'd0);
        read_chk("mcr_read0", 16'hFFFE, 16'h0000);
        bus.kb_valid = 1'b1; bus.kb_data = 8'h5A;
        tick();
        bus.kb_valid = 1'b0;
        bus_write(16'hFE06, 16'h0055);
        bus.mmio_addr = 16'hFE00;
        #2;
        rst = 1'b0;
        #1;
        chk("arst_mcr_run", {15'd0, bus.mcr_run}, 16'd1);
        chk("arst_fifo_empty", bus.mmio_rdata, 16'h0000);
        chk("arst_disp_valid", {15'd0, bus.disp_valid}, 16'd0);
        chk("arst_disp_data", {8'd0, bus.disp_data}, 16'h0000);
        chk("arst_kb_ready", {15'd0, bus.kb_ready}, 16'd1);
        tick();
        rst = 1'b1;
        tick();

        // randomized FIFO traffic against a queue model
        for (int cyc = 0; cyc < 300; cyc++) begin
            logic pick_kbdr;
            pick_kbdr      = ($urandom_range(0, 3) != 0);
            bus.mmio_addr  = pick_kbdr ? 16'hFE02 : 16'hFE00;
            bus.mmio_re    = ($urandom_range(0, 2) == 0);
            bus.kb_valid   = ($urandom_range(0, 1) == 1);
            bus.kb_data    = 8'($urandom);
            #1;
            chk("rnd_kb_ready", {15'd0, bus.kb_ready}, {15'd0, (model_q.size() < 4)});
            if (pick_kbdr)
                chk("rnd_kbdr", bus.mmio_rdata,
                    (model_q.size() != 0) ? {8'h00, model_q[0]} : 16'h0000);
            else
                chk("rnd_kbsr", bus.mmio_rdata, (model_q.size() != 0) ? 16'h8000 : 16'h0000);
            begin
                bit do_push;
                do_push = bus.kb_valid && (model_q.size() < 4);
                if (pick_kbdr && bus.mmio_re && model_q.size() != 0) void'(model_q.pop_front());
                if (do_push) model_q.push_back(bus.kb_data);
            end
            tick();
        end
        bus.kb_valid = 1'b0;
        bus.mmio_re  = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
